// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with stall, prioritised redirects,
// a one-entry pending-redirect buffer held across stalls, and a boot cycle.
// Optional macro PC_ALIGN_CHECK_EN replaces misaligned Jump/Branch targets by
// EXC_VEC and pulses Misalign for one cycle when that substitution is committed.
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_4180),
    parameter int                STEP      = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Exc,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpPC,
    input  logic              Branch,
    input  logic [ADDR_W-1:0] BranchPC,
    output logic [ADDR_W-1:0] PCNow,
    output logic [ADDR_W-1:0] PCPlus,
    output logic              Fetch_Valid,
    output logic              Redirect_Pending,
    output logic              Misalign
);
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pend_q, pend_d, pc_plus, tgt;
    logic              mis_q, mis_d, req, bad;

    // State register: PC, pending buffer, FSM state and misalign pulse
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            mis_q   <= mis_d;
        end
    end

    // Redirect target selection: Exc > Jump > Branch > sequential
    always_comb begin
        pc_plus = pc_q + STEP_V;
        req     = Exc | Jump | Branch;
`ifdef PC_ALIGN_CHECK_EN
        bad     = !Exc && (Jump ? |JumpPC[1:0] : (Branch && |BranchPC[1:0]));
`else
        bad     = 1'b0;
`endif
        tgt     = (Exc || bad) ? EXC_VEC : Jump ? JumpPC : Branch ? BranchPC : pc_plus;
    end

    // Next state: advance, capture a redirect during a stall, or release it
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        mis_d   = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                mis_d = bad;
                if (!Stall) begin
                    pc_d = tgt;
                end else if (req) begin
                    pend_d  = tgt;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (Stall) begin
                    pend_d = Exc ? EXC_VEC : pend_q;
                end else begin
                    pc_d    = Exc ? EXC_VEC : pend_q;
                    pend_d  = '0;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Outputs: fetch address, increment, and status flags
    always_comb begin
        PCNow            = pc_q;
        PCPlus           = pc_plus;
        Fetch_Valid      = (state_q != BOOT) && !Stall;
        Redirect_Pending = (state_q == HOLD);
        Misalign         = mis_q;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer, plus an
// 8-bit instance to observe wrap-around.
module tb_pc_sequencer;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Stall = 1'b0, Exc = 1'b0, Jump = 1'b0, Branch = 1'b0;
    logic [31:0] JumpPC = '0, BranchPC = '0;
    logic [31:0] PCNow, PCPlus;
    logic        Fetch_Valid, Redirect_Pending, Misalign;
    logic [7:0]  pc8, plus8;
    logic        fv8, rp8, mis8;
    int          passed = 0;
    int          total = 0;

    always #5 Clk = ~Clk;

    pc_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Exc(Exc), .Jump(Jump), .JumpPC(JumpPC),
        .Branch(Branch), .BranchPC(BranchPC), .PCNow(PCNow), .PCPlus(PCPlus),
        .Fetch_Valid(Fetch_Valid), .Redirect_Pending(Redirect_Pending), .Misalign(Misalign)
    );

    pc_sequencer #(.ADDR_W(8), .RESET_VEC(8'hFC)) dut8 (
        .Clk(Clk), .Rst(Rst), .Stall(1'b0), .Exc(1'b0), .Jump(1'b0), .JumpPC(8'h00),
        .Branch(1'b0), .BranchPC(8'h00), .PCNow(pc8), .PCPlus(plus8),
        .Fetch_Valid(fv8), .Redirect_Pending(rp8), .Misalign(mis8)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // reset held for two cycles
        step();
        step();
        Rst = 1'b0;
        chk("rst_pc", PCNow, 32'h3000);
        chk("rst_fv", {31'b0, Fetch_Valid}, 0);
        chk("rst_rp", {31'b0, Redirect_Pending}, 0);
        chk("rst_mis", {31'b0, Misalign}, 0);
        chk("rst_pc8", {24'b0, pc8}, 32'hFC);
        chk("boot_fv8", {31'b0, fv8}, 0);
        Jump = 1'b1; JumpPC = 32'h3700;
        step();
        Jump = 1'b0;
        chk("boot_pc", PCNow, 32'h3000);
        chk("boot_fv", {31'b0, Fetch_Valid}, 1);
        chk("plus", PCPlus, 32'h3004);
        chk("run_pc8", {24'b0, pc8}, 32'hFC);
        chk("plus8_wrap", {24'b0, plus8}, 32'h00);
        step();
        chk("seq1", PCNow, 32'h3004);
        chk("wrap_pc8", {24'b0, pc8}, 32'h00);
        chk("plus8", {24'b0, plus8}, 32'h04);
        step();
        chk("seq2", PCNow, 32'h3008);
        // priority: Jump over Branch, then Exc over all
        Jump = 1'b1; JumpPC = 32'h3100; Branch = 1'b1; BranchPC = 32'h3200;
        step();
        chk("jump_over_branch", PCNow, 32'h3100);
        Exc = 1'b1;
        step();
        chk("exc_over_all", PCNow, 32'h4180);
        Exc = 1'b0; Jump = 1'b0; Branch = 1'b0;
        // branch captured in first stall cycle
        Stall = 1'b1; Branch = 1'b1; BranchPC = 32'h3040;
        #1;
        chk("stall_fv", {31'b0, Fetch_Valid}, 0);
        step();
        Branch = 1'b0;
        chk("hold_pc1", PCNow, 32'h4180);
        chk("hold_rp1", {31'b0, Redirect_Pending}, 1);
        step();
        step();
        chk("hold_pc3", PCNow, 32'h4180);
        chk("hold_rp3", {31'b0, Redirect_Pending}, 1);
        Stall = 1'b0;
        #1;
        chk("hold_fv", {31'b0, Fetch_Valid}, 1);
        step();
        chk("release_pc", PCNow, 32'h3040);
        chk("release_rp", {31'b0, Redirect_Pending}, 0);
        // Exc overwrites the pending target
        Stall = 1'b1; Jump = 1'b1; JumpPC = 32'h3500;
        step();
        Jump = 1'b0; Exc = 1'b1;
        step();
        Exc = 1'b0; Stall = 1'b0;
        step();
        chk("exc_overwrite", PCNow, 32'h4180);
        // Jump during HOLD and during release is ignored
        Stall = 1'b1; Branch = 1'b1; BranchPC = 32'h3060;
        step();
        Branch = 1'b0; Jump = 1'b1; JumpPC = 32'h3500;
        step();
        chk("hold_keep_pc", PCNow, 32'h4180);
        Stall = 1'b0;
        step();
        Jump = 1'b0;
        chk("first_wins", PCNow, 32'h3060);
        chk("first_wins_rp", {31'b0, Redirect_Pending}, 0);
        // Exc in the release cycle beats the pending target
        Stall = 1'b1; Branch = 1'b1; BranchPC = 32'h3080;
        step();
        Branch = 1'b0; Stall = 1'b0; Exc = 1'b1;
        step();
        Exc = 1'b0;
        chk("exc_release", PCNow, 32'h4180);
        // reset while holding a redirect
        Stall = 1'b1; Branch = 1'b1; BranchPC = 32'h30C0;
        step();
        chk("pre_rst_rp", {31'b0, Redirect_Pending}, 1);
        Rst = 1'b1;
        step();
        Rst = 1'b0; Branch = 1'b0; Stall = 1'b0;
        chk("midrst_pc", PCNow, 32'h3000);
        chk("midrst_rp", {31'b0, Redirect_Pending}, 0);
        chk("midrst_fv", {31'b0, Fetch_Valid}, 0);
        step();
        chk("midrst_boot", PCNow, 32'h3000);
        step();
        chk("midrst_seq", PCNow, 32'h3004);
        // misaligned jump target
        Jump = 1'b1; JumpPC = 32'h3102;
        step();
        Jump = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc", PCNow, 32'h4180);
        chk("mis_pulse", {31'b0, Misalign}, 1);
        step();
        chk("mis_clear", {31'b0, Misalign}, 0);
        chk("mis_next", PCNow, 32'h4184);
`else
        chk("mis_pc", PCNow, 32'h3102);
        chk("mis_pulse", {31'b0, Misalign}, 0);
        step();
        chk("mis_clear", {31'b0, Misalign}, 0);
        chk("mis_next", PCNow, 32'h3106);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the pipelined CPU. It replaces the single-cycle next-PC mux with a registered PC, and adds:
- stall (hold),
- exception redirect with fixed priority,
- a one-entry pending-redirect buffer that keeps a redirect arriving during a stall,
- a boot cycle after reset.

It drives the fetch address into the instruction memory/IFU and PCPlus into the F/D pipeline register.

Parameters:
ADDR_W, 32, PC width in bits
RESET_VEC, 32'h0000_3000, PC value after reset
EXC_VEC, 32'h0000_4180, exception handler entry
STEP, 4, sequential increment; must be a multiple of 4

Ports:
Clk  in  1  clock; all state updates on the rising edge
Rst  in  1  synchronous, active-high reset
Stall  in  1  hold PC (from hazard unit)
Exc  in  1  exception redirect request
Jump  in  1  jump redirect request
JumpPC  in  ADDR_W  jump target
Branch  in  1  taken-branch redirect request
BranchPC  in  ADDR_W  branch target
PCNow  out  ADDR_W  current fetch address (registered)
PCPlus  out  ADDR_W  PCNow+STEP, combinational
Fetch_Valid  out  1  PCNow is a valid fetch this cycle
Redirect_Pending  out  1  a buffered redirect is waiting
Misalign  out  1  misaligned redirect target flagged (see Optional Feature)

Behaviour:
- Reset (Rst=1 at an edge) forces:
  - PCNow=RESET_VEC, state=BOOT, pending buffer cleared;
  - Redirect_Pending=0, Misalign=0.
  - Reset overrides all other inputs in any state, including mid-stall with a pending redirect.
- FSM has three states: BOOT, RUN, HOLD.
- BOOT:
  - Fetch_Valid=0; all inputs except Rst are ignored; PC is not advanced.
  - Next edge goes to RUN with PCNow=RESET_VEC, so the first valid fetch is RESET_VEC.
- Redirect target priority, computed combinationally: Exc > Jump > Branch > sequential.
  - Exc target=EXC_VEC, Jump target=JumpPC, Branch target=BranchPC, sequential target=PCPlus.
- RUN:
  - Fetch_Valid = !Stall.
  - Stall=0: PCNow <= selected target; stay in RUN.
  - Stall=1, no request: PCNow holds.
  - Stall=1 with any of Exc/Jump/Branch: the selected target is captured in the pending register; PCNow holds; go to HOLD.
- HOLD:
  - Redirect_Pending=1; Fetch_Valid = !Stall.
  - Stall=1: PCNow holds. Exc=1 overwrites the pending target with EXC_VEC. Jump/Branch are ignored, so the first-captured redirect wins.
  - Stall=0: PCNow <= pending target, or EXC_VEC if Exc=1 in that same cycle. Jump/Branch in that cycle are ignored. Pending is cleared; go to RUN.
- Latency: a redirect presented with Stall=0 appears on PCNow at the next edge (one cycle).
- Width: PCPlus = (PCNow+STEP) mod 2^ADDR_W; wrap at 2^ADDR_W-STEP is silent.
- Simultaneous Exc+Jump+Branch: Exc wins. Jump+Branch together: Jump wins.
- Redirect_Pending is registered and is 1 exactly in HOLD.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined:
  - A Jump/Branch target with nonzero bits [1:0], if it would be selected or captured, is replaced by EXC_VEC.
  - Misalign is registered and pulses 1 for exactly one cycle, on the edge the substitution is committed to PCNow or to the pending register.
  - Exc targets are never checked.
- Not defined: Misalign is tied to 0; targets are loaded unmodified.

Test Plan:
1. Reset sequence: Rst=1 for 2 cycles, then 0 → PCNow=0x3000 with Fetch_Valid=0 for one cycle; then 0x3000 valid; then 0x3004, 0x3008.
2. Redirect priority: at PCNow=0x3008, Stall=0, Jump=1 JumpPC=0x3100 and Branch=1 BranchPC=0x3200 → next PCNow=0x3100. Repeat with Exc=1 added → 0x4180.
3. Redirect buffered during stall: Stall=1 for 3 cycles, Branch=1 BranchPC=0x3040 in the first stall cycle only → PCNow holds, Redirect_Pending=1. Edge after Stall drops → PCNow=0x3040, Redirect_Pending=0.
4. Pending overwritten or kept in HOLD:
   - Exc=1 → pending becomes 0x4180; PCNow=0x4180 after release.
   - Jump=1 JumpPC=0x3500 during HOLD → ignored; the original target is loaded.
5. Mid-stall reset and wrap:
   - Rst=1 while in HOLD → BOOT, PCNow=0x3000, Redirect_Pending=0.
   - ADDR_W=8, RESET_VEC=8'hFC → sequence 0xFC, 0x00.
6. With PC_ALIGN_CHECK_EN: Jump=1 JumpPC=0x3102, Stall=0 → PCNow=0x4180 and a one-cycle Misalign pulse. Without the macro → PCNow=0x3102 and Misalign=0.
